// File: rtl/axi_stream_if.sv
// ---------------------------------------------------------------------------
// axi_stream_if
// One AXI4-Stream lane in OpenNIC shape: a 512-bit data word, a 64-bit byte
// keep, end-of-packet, and three 16-bit user fields (size, src, dst).
//   valid      : master -> slave, beat present
//   ready      : slave  -> master, beat can be taken
//   data       : 512-bit payload word
//   keep       : byte enables for data
//   last       : final beat of a packet
//   user_size  : packet size in bytes
//   user_src   : source id
//   user_dst   : destination id
// ---------------------------------------------------------------------------
interface axi_stream_if;
   logic         valid;
   logic         ready;
   logic [511:0] data;
   logic [63:0]  keep;
   logic         last;
   logic [15:0]  user_size;
   logic [15:0]  user_src;
   logic [15:0]  user_dst;

   modport master (
      output valid, data, keep, last, user_size, user_src, user_dst,
      input  ready
   );

   modport slave (
      input  valid, data, keep, last, user_size, user_src, user_dst,
      output ready
   );
endinterface

// File: rtl/axi_stream_if_s_connector_reg.sv
// ---------------------------------------------------------------------------
// axi_stream_if_s_connector_reg
// Receive-side connector: turns COUNTS flat AXI4-Stream lanes into an array
// of axi_stream_if master ports. Every lane has a 2-entry skid register slice,
// so tready and all outgoing payload come straight from flops, and a
// packet counter that counts delivered beats carrying last=1.
//
// Parameters
//   COUNTS     number of independent lanes
//   CNT_WIDTH  width of each per-lane packet counter (wraps, no saturation)
//
// Ports
//   axis_aclk          in   stream clock
//   axis_rst           in   synchronous active-high reset
//   s_axis_tvalid      in   [COUNTS]           lane valid
//   s_axis_tdata       in   [512*COUNTS]       lane data, lane i at [512*i +: 512]
//   s_axis_tkeep       in   [64*COUNTS]        lane byte keep
//   s_axis_tlast       in   [COUNTS]           lane end of packet
//   s_axis_tuser_size  in   [16*COUNTS]        lane packet size in bytes
//   s_axis_tuser_src   in   [16*COUNTS]        lane source id
//   s_axis_tuser_dst   in   [16*COUNTS]        lane destination id
//   s_axis_tready      out  [COUNTS]           lane ready (registered)
//   m_axis[COUNTS]     if   axi_stream_if.master output lanes
//   m_pkt_cnt          out  [CNT_WIDTH*COUNTS] packets delivered per lane
// ---------------------------------------------------------------------------
module axi_stream_if_s_connector_reg #(
   parameter int COUNTS    = 1,
   parameter int CNT_WIDTH = 32
) (
   input  logic                          axis_aclk,
   input  logic                          axis_rst,
   input  logic [COUNTS-1:0]             s_axis_tvalid,
   input  logic [512*COUNTS-1:0]         s_axis_tdata,
   input  logic [64*COUNTS-1:0]          s_axis_tkeep,
   input  logic [COUNTS-1:0]             s_axis_tlast,
   input  logic [16*COUNTS-1:0]          s_axis_tuser_size,
   input  logic [16*COUNTS-1:0]          s_axis_tuser_src,
   input  logic [16*COUNTS-1:0]          s_axis_tuser_dst,
   output logic [COUNTS-1:0]             s_axis_tready,
   axi_stream_if.master                  m_axis [COUNTS],
   output logic [CNT_WIDTH*COUNTS-1:0]   m_pkt_cnt
);

   // Payload layout {data, keep, last, size, src, dst}, dst in the LSBs.
   localparam int PAY_W    = 625;
   localparam int OFF_DST  = 0;
   localparam int OFF_SRC  = 16;
   localparam int OFF_SIZE = 32;
   localparam int OFF_LAST = 48;
   localparam int OFF_KEEP = 49;
   localparam int OFF_DATA = 113;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   for (genvar g = 0; g < COUNTS; g++) begin : g_lane
      state_t               r_state;
      state_t               w_state_nxt;
      logic                 r_tready;
      logic [PAY_W-1:0]     r_out;
      logic [PAY_W-1:0]     r_skid;
      logic [PAY_W-1:0]     w_in;
      logic [CNT_WIDTH-1:0] r_cnt;
      logic                 w_s_accept;
      logic                 w_m_take;
      logic                 w_load_out_in;
      logic                 w_load_out_skid;
      logic                 w_load_skid;

      assign w_in = {s_axis_tdata[512*g +: 512],
                     s_axis_tkeep[64*g +: 64],
                     s_axis_tlast[g],
                     s_axis_tuser_size[16*g +: 16],
                     s_axis_tuser_src[16*g +: 16],
                     s_axis_tuser_dst[16*g +: 16]};

      assign w_s_accept = s_axis_tvalid[g] & r_tready;
      assign w_m_take   = (r_state != EMPTY) & m_axis[g].ready;

      always_comb begin
         w_state_nxt     = r_state;
         w_load_out_in   = 1'b0;
         w_load_out_skid = 1'b0;
         w_load_skid     = 1'b0;
         case (r_state)
            EMPTY: begin
               if (w_s_accept) begin
                  w_load_out_in = 1'b1;
                  w_state_nxt   = BUSY;
               end
            end
            BUSY: begin
               if (w_s_accept && !w_m_take) begin
                  w_load_skid = 1'b1;
                  w_state_nxt = FULL;
               end else if (w_s_accept && w_m_take) begin
                  w_load_out_in = 1'b1;
               end else if (w_m_take) begin
                  w_state_nxt = EMPTY;
               end
            end
            FULL: begin
               // tready is low here, so only the drain side can move.
               if (w_m_take) begin
                  w_load_out_skid = 1'b1;
                  w_state_nxt     = BUSY;
               end
            end
            default: w_state_nxt = EMPTY;
         endcase
      end

      // Control state: reset clears occupancy, so held beats are dropped.
      always_ff @(posedge axis_aclk) begin
         if (axis_rst) begin
            r_state  <= EMPTY;
            r_tready <= 1'b0;
            r_cnt    <= '0;
         end else begin
            r_state  <= w_state_nxt;
            // Registered ready: low exactly while both entries are occupied.
            r_tready <= (w_state_nxt != FULL);
            if (w_m_take && r_out[OFF_LAST]) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end

      // Payload storage: no reset, contents are ignored while valid is low.
      always_ff @(posedge axis_aclk) begin
         if (w_load_out_in) begin
            r_out <= w_in;
         end else if (w_load_out_skid) begin
            r_out <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= w_in;
         end
      end

      assign s_axis_tready[g]                    = r_tready;
      assign m_pkt_cnt[CNT_WIDTH*g +: CNT_WIDTH] = r_cnt;

      assign m_axis[g].valid     = (r_state != EMPTY);
      assign m_axis[g].data      = r_out[OFF_DATA +: 512];
      assign m_axis[g].keep      = r_out[OFF_KEEP +: 64];
      assign m_axis[g].last      = r_out[OFF_LAST];
      assign m_axis[g].user_size = r_out[OFF_SIZE +: 16];
      assign m_axis[g].user_src  = r_out[OFF_SRC +: 16];
      assign m_axis[g].user_dst  = r_out[OFF_DST +: 16];
   end

endmodule
